// File: rtl/soc_pwm_ctrl.sv
// soc_pwm_ctrl: multi-channel PWM generator behind an Avalon-MM slave.
// A shared prescaler produces a tick that advances a period counter. Each
// channel compares the counter against its active duty value. PERIOD and DUTY
// writes land in shadow registers and are copied to the active set only at a
// period boundary (or when the block is enabled), so outputs never glitch.
module soc_pwm_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_PRESC  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3);

  // Software-visible registers
  logic [2:0]         ctrl_reg;
  logic [CNT_W-1:0]   period_sh;
  logic [PRESC_W-1:0] presc_reg;
  logic               done;
  logic [CNT_W-1:0]   duty_sh  [NUM_CH];

  // Active (applied) copies and free-running state
  logic [CNT_W-1:0]   period_act;
  logic [CNT_W-1:0]   duty_act [NUM_CH];
  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   cnt;

  // Decode and control strobes
  logic               wr_en;
  logic               wr_ctrl;
  logic               wr_period;
  logic               wr_presc;
  logic               wr_status;
  logic [NUM_CH-1:0]  wr_duty;
  logic               en;
  logic               inv;
  logic               irq_en;
  logic               en_rise;
  logic               tick;
  logic               boundary;
  logic               load_act;
  logic [NUM_CH-1:0]  raw;

  // Only the low bits of writedata are meaningful for any register.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en & (address == ADDR_CTRL);
  assign wr_period = wr_en & (address == ADDR_PERIOD);
  assign wr_presc  = wr_en & (address == ADDR_PRESC);
  assign wr_status = wr_en & (address == ADDR_STATUS);

  assign en     = ctrl_reg[0];
  assign inv    = ctrl_reg[1];
  assign irq_en = ctrl_reg[2];

  // Enabling copies the shadows straight into the active set so the first
  // period already uses the programmed values.
  assign en_rise  = wr_ctrl & writedata[0] & ~en;
  // A prescaler that has run past a freshly lowered PRESCALE never matches
  // until it wraps through zero, which yields no tick.
  assign tick     = en & (presc_cnt == presc_reg);
  assign boundary = tick & (cnt == period_act);
  assign load_act = boundary | en_rise;

  assign irq = irq_en & done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_duty[gi] = wr_en & (address == ADDR_W'(4 + gi));
      assign raw[gi]     = en & (cnt < duty_act[gi]);
    end
  endgenerate

  // Control, period, prescale registers and the sticky DONE flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg   <= '0;
      period_sh  <= '0;
      presc_reg  <= '0;
      period_act <= '0;
      done       <= 1'b0;
    end else begin
      if (wr_ctrl)   ctrl_reg  <= writedata[2:0];
      if (wr_period) period_sh <= writedata[CNT_W-1:0];
      if (wr_presc)  presc_reg <= writedata[PRESC_W-1:0];
      if (load_act)  period_act <= period_sh;
      // Boundary set takes priority over a simultaneous write-1-to-clear.
      if (boundary)
        done <= 1'b1;
      else if (wr_status && writedata[0])
        done <= 1'b0;
    end
  end

  // Duty shadow registers and their active copies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty[i]) duty_sh[i]  <= writedata[CNT_W-1:0];
        if (load_act)   duty_act[i] <= duty_sh[i];
      end
    end
  end

  // Prescaler and period counter; both held at zero while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else if (!en) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else begin
      if (tick)
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + PRESC_W'(1);
      if (boundary)
        cnt <= '0;
      else if (tick)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered PWM outputs with optional global inversion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pwm_out <= '0;
    else
      pwm_out <= raw ^ {NUM_CH{inv}};
  end

  // Zero-wait-state read mux; shadows are returned for PERIOD and DUTY
  always_comb begin
    readdata = '0;
    if (address == ADDR_CTRL)
      readdata = 32'(ctrl_reg);
    else if (address == ADDR_PERIOD)
      readdata = 32'(period_sh);
    else if (address == ADDR_PRESC)
      readdata = 32'(presc_reg);
    else if (address == ADDR_STATUS)
      readdata = (32'(cnt) << 16) | 32'(done);
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_W'(4 + i))
        readdata = 32'(duty_sh[i]);
    end
  end

endmodule

// File: tb/tb_soc_pwm_ctrl.sv
// tb_soc_pwm_ctrl: directed test of soc_pwm_ctrl with hand-computed
// expectations. Edge numbering: E0 is the edge that captures the enabling
// CTRL write; after edge Ek the counter holds the value it took at Ek and
// pwm_out reflects the counter value that was present before Ek.
module tb_soc_pwm_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  pwm_out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  soc_pwm_ctrl #(
    .NUM_CH (4),
    .CNT_W  (8),
    .PRESC_W(16),
    .ADDR_W (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .pwm_out   (pwm_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic idle(input logic [3:0] a);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    address    = a;
  endtask

  task automatic drive_wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  // One-cycle register write, captured on the next rising edge
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    drive_wr(a, d);
    @(negedge clk);
    #1;
    idle(a);
  endtask

  // Disable, clear DONE, then enable with the given CTRL value (edge E0)
  task automatic restart(input logic [31:0] c);
    wr(4'd0, 32'd0);
    wr(4'd3, 32'd1);
    wr(4'd0, c);
    idle(4'd3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(4'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pwm got=%b exp=0000", pwm_out);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      $display("read addr=%0d data=%h", a, readdata);
      n_checks++;
      if (readdata !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got=%h exp=0", a, readdata);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_basic();
    int c;
    logic [3:0]  exp_pwm;
    logic [31:0] exp_st;
    wr(4'd2, 32'd0);
    wr(4'd1, 32'd9);
    wr(4'd4, 32'd3);
    wr(4'd5, 32'd0);
    wr(4'd6, 32'd10);
    wr(4'd7, 32'hFFFF_FF05);   // upper bits must be ignored
    address = 4'd1;
    #1;
    n_checks++;
    if (readdata !== 32'd9) begin
      n_fail++;
      $display("FAIL period_readback got=%h exp=9", readdata);
    end
    address = 4'd7;
    #1;
    n_checks++;
    if (readdata !== 32'd5) begin
      n_fail++;
      $display("FAIL duty3_readback got=%h exp=5", readdata);
    end
    wr(4'd0, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      idle(4'd3);
      @(negedge clk);
      #1;
      c = (k - 1) % 10;
      exp_pwm = {c < 5, 1'b1, 1'b0, c < 3};
      exp_st  = (32'(k % 10) << 16) | ((k >= 10) ? 32'd1 : 32'd0);
      $display("basic k=%0d pwm=%b status=%h", k, pwm_out, readdata);
      n_checks++;
      if (pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL basic_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
      end
      n_checks++;
      if (readdata !== exp_st) begin
        n_fail++;
        $display("FAIL basic_status k=%0d got=%h exp=%h", k, readdata, exp_st);
      end
    end
  endtask

  task automatic test_shadow();
    int c;
    int th;
    logic [3:0] exp_pwm;
    restart(32'd1);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5)
        drive_wr(4'd4, 32'd7);        // mid-period write
      else if (k == 20)
        drive_wr(4'd4, 32'd2);        // lands on the boundary edge E20
      else
        idle(4'd3);
      @(negedge clk);
      #1;
      c  = (k - 1) % 10;
      th = (k <= 10) ? 3 : ((k <= 30) ? 7 : 2);
      exp_pwm = {c < 5, 1'b1, 1'b0, c < th};
      $display("shadow k=%0d pwm=%b", k, pwm_out);
      n_checks++;
      if (pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL shadow_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
      end
    end
    address = 4'd4;
    #1;
    n_checks++;
    if (readdata !== 32'd2) begin
      n_fail++;
      $display("FAIL shadow_readback got=%h exp=2", readdata);
    end
  endtask

  task automatic test_prescale();
    int cp;
    logic [3:0]  exp_pwm;
    logic [31:0] exp_st;
    wr(4'd2, 32'd3);
    wr(4'd1, 32'd4);
    restart(32'd1);
    for (int k = 1; k <= 24; k++) begin
      idle(4'd3);
      @(negedge clk);
      #1;
      cp = ((k - 1) / 4) % 5;
      exp_pwm = {1'b1, 1'b1, 1'b0, cp < 2};
      exp_st  = (32'((k / 4) % 5) << 16) | ((k >= 20) ? 32'd1 : 32'd0);
      $display("presc k=%0d pwm=%b status=%h", k, pwm_out, readdata);
      n_checks++;
      if (pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL presc_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
      end
      n_checks++;
      if (readdata !== exp_st) begin
        n_fail++;
        $display("FAIL presc_status k=%0d got=%h exp=%h", k, readdata, exp_st);
      end
    end
  endtask

  task automatic test_irq();
    logic exp_irq;
    wr(4'd2, 32'd0);
    wr(4'd1, 32'd9);
    restart(32'd5);
    for (int k = 1; k <= 22; k++) begin
      if (k == 13 || k == 20)
        drive_wr(4'd3, 32'd1);        // k=20 coincides with a boundary
      else
        idle(4'd3);
      @(negedge clk);
      #1;
      exp_irq = ((k >= 10) && (k <= 12)) || (k >= 20);
      $display("irq k=%0d irq=%b done=%b", k, irq, readdata[0]);
      n_checks++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL irq_level k=%0d got=%b exp=%b", k, irq, exp_irq);
      end
      n_checks++;
      if (readdata[0] !== exp_irq) begin
        n_fail++;
        $display("FAIL irq_done k=%0d got=%b exp=%b", k, readdata[0], exp_irq);
      end
    end
  endtask

  task automatic test_inv_disable();
    int c;
    logic [3:0] exp_pwm;
    restart(32'd3);
    for (int k = 1; k <= 10; k++) begin
      idle(4'd3);
      @(negedge clk);
      #1;
      c = (k - 1) % 10;
      exp_pwm = ~{c < 5, 1'b1, 1'b0, c < 2};
      $display("inv k=%0d pwm=%b", k, pwm_out);
      n_checks++;
      if (pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL inv_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
      end
    end
    for (int k = 11; k <= 13; k++) begin
      if (k == 11)
        drive_wr(4'd0, 32'd2);
      else
        idle(4'd3);
      @(negedge clk);
      #1;
      if (k >= 12) begin
        $display("disable k=%0d pwm=%b cnt=%0d", k, pwm_out, readdata[31:16]);
        n_checks++;
        if (pwm_out !== 4'b1111) begin
          n_fail++;
          $display("FAIL disable_pwm k=%0d got=%b exp=1111", k, pwm_out);
        end
        n_checks++;
        if (readdata[31:16] !== 16'd0) begin
          n_fail++;
          $display("FAIL disable_cnt k=%0d got=%0d exp=0", k, readdata[31:16]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    restart(32'd1);
    repeat (2) begin
      idle(4'd3);
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (pwm_out !== 4'b1101) begin
      n_fail++;
      $display("FAIL pre_reset_pwm got=%b exp=1101", pwm_out);
    end
    address = 4'd0;
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset pwm=%b irq=%b ctrl=%h", pwm_out, irq, readdata);
    n_checks++;
    if (pwm_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_pwm got=%b exp=0000", pwm_out);
    end
    n_checks++;
    if (readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_ctrl got=%h exp=0", readdata);
    end
    address = 4'd4;
    #1;
    n_checks++;
    if (readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_duty0 got=%h exp=0", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    idle(4'd0);
    test_reset();
    test_basic();
    test_shadow();
    test_prescale();
    test_irq();
    test_inv_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
